// File: rtl/lcd_pkg.sv
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and constants for the HD44780-style LCD
//                controller: FSM state encoding, command bytes, init ROM
//                and timer width.
//  Config      : LCD_CTRL_INIT_SEQ_EN - includes the power-on init ROM
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_TMR_W = 20;

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
        INIT_LOAD = 3'd1,
        SETUP     = 3'd2,
        PULSE     = 3'd3,
        HOLD      = 3'd4,
        WAIT      = 3'd5,
        IDLE      = 3'd6
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

`ifdef LCD_CTRL_INIT_SEQ_EN
    // Entry 0 is sent first.
    localparam logic [3:0][7:0] LCD_INIT_ROM = {
        LCD_CMD_ENTRY, LCD_CMD_CLEAR, LCD_CMD_DISPON, LCD_CMD_FUNCSET
    };
`endif

    // Clear and home commands need the long post-transfer wait.
    function automatic logic lcd_is_long_wait(input logic rs, input logic [7:0] data);
        return (!rs) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_timer.sv
// ============================================================================
//  Module      : lcd_timer
//  Description : Loadable down-counter with zero flag; saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timer #(
    parameter int        W       = 20,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= RST_VAL;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl.sv
// ============================================================================
//  Module      : lcd_ctrl
//  Description : Write-only parallel LCD controller. Sequences SETUP/PULSE/
//                HOLD/WAIT timing for each byte from a valid/ready port and,
//                optionally, runs the power-on init sequence itself.
//  Config      : LCD_CTRL_INIT_SEQ_EN - power-up wait and automatic init
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC  = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data,
    output logic       o_init_done
);

    localparam int TMR_MAX = (1 << LCD_TMR_W);

    generate
        if (POWERUP_CYC  < 1 || POWERUP_CYC  >= TMR_MAX ||
            SETUP_CYC    < 1 || SETUP_CYC    >= TMR_MAX ||
            PULSE_CYC    < 1 || PULSE_CYC    >= TMR_MAX ||
            HOLD_CYC     < 1 || HOLD_CYC     >= TMR_MAX ||
            CMD_WAIT_CYC < 1 || CMD_WAIT_CYC >= TMR_MAX ||
            CLR_WAIT_CYC < 1 || CLR_WAIT_CYC >= TMR_MAX) begin : g_param_chk
            $error("lcd_ctrl: every timing parameter must be in 1 .. 2**20-1");
        end
    endgenerate

    localparam logic [LCD_TMR_W-1:0] c_pwrup_ld = LCD_TMR_W'(POWERUP_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] c_setup_ld = LCD_TMR_W'(SETUP_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] c_pulse_ld = LCD_TMR_W'(PULSE_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] c_hold_ld  = LCD_TMR_W'(HOLD_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] c_cmd_ld   = LCD_TMR_W'(CMD_WAIT_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] c_clr_ld   = LCD_TMR_W'(CLR_WAIT_CYC - 1);

    lcd_state_e state_q, state_d;
    logic       rdy_q,  rdy_d;
    logic       on_q,   on_d;
    logic       en_q,   en_d;
    logic       rs_q,   rs_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
`ifdef LCD_CTRL_INIT_SEQ_EN
    logic [1:0] idx_q,  idx_d;
`endif

    logic                 w_accept;
    logic                 w_tmr_load;
    logic [LCD_TMR_W-1:0] w_tmr_val;
    logic                 w_tmr_zero;

    // rdy_q is only ever set while in IDLE, so it alone qualifies acceptance.
    assign w_accept = i_req_vld & rdy_q;

    lcd_timer #(
        .W       (LCD_TMR_W),
        .RST_VAL (c_pwrup_ld)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Next-state, timer reload on each state entry, and output next values.
    always_comb begin
        state_d    = state_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        rs_d       = rs_q;
        data_d     = data_q;
`ifdef LCD_CTRL_INIT_SEQ_EN
        on_d       = on_q;
        done_d     = done_q;
        idx_d      = idx_q;
`else
        on_d       = 1'b1;
        done_d     = 1'b1;
`endif

        case (state_q)
`ifdef LCD_CTRL_INIT_SEQ_EN
            PWRUP: begin
                if (w_tmr_zero) begin
                    state_d = INIT_LOAD;
                    on_d    = 1'b1;
                end
            end
            INIT_LOAD: begin
                rs_d       = 1'b0;
                data_d     = LCD_INIT_ROM[idx_q];
                state_d    = SETUP;
                w_tmr_load = 1'b1;
                w_tmr_val  = c_setup_ld;
            end
`endif
            IDLE: begin
                if (w_accept) begin
                    rs_d       = i_req_rs;
                    data_d     = i_req_data;
                    state_d    = SETUP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_setup_ld;
                end
            end
            SETUP: begin
                if (w_tmr_zero) begin
                    state_d    = PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_pulse_ld;
                end
            end
            PULSE: begin
                if (w_tmr_zero) begin
                    state_d    = HOLD;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_hold_ld;
                end
            end
            HOLD: begin
                if (w_tmr_zero) begin
                    state_d    = WAIT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = lcd_is_long_wait(rs_q, data_q) ? c_clr_ld : c_cmd_ld;
                end
            end
            WAIT: begin
                if (w_tmr_zero) begin
`ifdef LCD_CTRL_INIT_SEQ_EN
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_LOAD;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
`ifdef LCD_CTRL_INIT_SEQ_EN
                state_d    = PWRUP;
                w_tmr_load = 1'b1;
                w_tmr_val  = c_pwrup_ld;
`else
                state_d    = IDLE;
`endif
            end
        endcase

        // Ready is raised one cycle after IDLE is entered, giving the +1 in
        // the accept-to-ready latency, and dropped on the accepting edge.
        rdy_d = (state_q == IDLE) && !w_accept;
        en_d  = (state_d == PULSE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef LCD_CTRL_INIT_SEQ_EN
            state_q <= PWRUP;
            idx_q   <= 2'd0;
`else
            state_q <= IDLE;
`endif
            rdy_q   <= 1'b0;
            on_q    <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
`ifdef LCD_CTRL_INIT_SEQ_EN
            idx_q   <= idx_d;
`endif
            rdy_q   <= rdy_d;
            on_q    <= on_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_req_rdy   = rdy_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;
    assign o_init_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
//  Module      : tb_lcd_ctrl
//  Description : Self-checking bench for lcd_ctrl with a scoreboard of
//                expected EN-strobe payloads and latency checks.
//  Config      : LCD_CTRL_INIT_SEQ_EN - selects the init-sequence scenarios
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_req_vld = 1'b0;
    logic       i_req_rs = 1'b0;
    logic [7:0] i_req_data = 8'h00;
    logic       o_req_rdy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_init_done;
    logic [7:0] o_lcd_data;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    bit abort  = 1'b0;
    logic [8:0] exp_q [$];

    lcd_ctrl #(
        .POWERUP_CYC  (100),
        .SETUP_CYC    (2),
        .PULSE_CYC    (4),
        .HOLD_CYC     (2),
        .CMD_WAIT_CYC (10),
        .CLR_WAIT_CYC (50)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_vld   (i_req_vld),
        .i_req_rs    (i_req_rs),
        .i_req_data  (i_req_data),
        .o_req_rdy   (o_req_rdy),
        .o_lcd_on    (o_lcd_on),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_data  (o_lcd_data),
        .o_init_done (o_init_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // EN strobe monitor: pops the scoreboard on each rising EN and checks width.
    logic prev_en = 1'b0;
    int   width   = 0;
    always @(negedge i_clk) begin
        if (o_lcd_en && !prev_en) begin
            pulses++;
            width = 1;
            chk("pulse_rw", {31'd0, o_lcd_rw}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("pulse_rs",   {31'd0, o_lcd_rs},  {31'd0, e[8]});
                chk("pulse_data", {24'd0, o_lcd_data}, {24'd0, e[7:0]});
            end
        end else if (o_lcd_en && prev_en) begin
            width++;
        end else if (!o_lcd_en && prev_en && !abort) begin
            chk("pulse_width", width, 32'd4);
        end
        prev_en = o_lcd_en;
    end

    task automatic wait_rdy();
        int k;
        k = 0;
        @(negedge i_clk);
        while (!o_req_rdy && k < 2000) begin
            @(negedge i_clk);
            k++;
        end
        if (!o_req_rdy) chk("rdy_timeout", 32'd0, 32'd1);
    endtask

    // One request; checks EN placement, captured bus and ready latency.
    task automatic send(input logic rs, input logic [7:0] d, input int lat);
        int n;
        wait_rdy();
        i_req_vld = 1'b1; i_req_rs = rs; i_req_data = d;
        @(posedge i_clk);
        exp_q.push_back({rs, d});
        #1;
        i_req_vld = 1'b0; i_req_data = 8'hFF; i_req_rs = ~rs;
        chk("rdy_drop", {31'd0, o_req_rdy}, 32'd0);
        n = 0;
        while (n < 200) begin
            @(posedge i_clk); #1; n++;
            if (n == 1) begin
                chk("bus_rs",   {31'd0, o_lcd_rs},  {31'd0, rs});
                chk("bus_data", {24'd0, o_lcd_data}, {24'd0, d});
                chk("en_setup", {31'd0, o_lcd_en}, 32'd0);
            end
            if (n == 2) chk("en_rise", {31'd0, o_lcd_en}, 32'd1);
            if (n == 5) chk("en_last", {31'd0, o_lcd_en}, 32'd1);
            if (n == 6) chk("en_fall", {31'd0, o_lcd_en}, 32'd0);
            if (o_req_rdy) break;
        end
        chk($sformatf("latency_%0d_%02h", rs, d), n, lat);
    endtask

`ifdef LCD_CTRL_INIT_SEQ_EN
    task automatic run_init();
        int n;
        int base;
        base = pulses;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        @(negedge i_clk);
        i_reset = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(posedge i_clk); #1; n++;
            if (o_lcd_on) break;
        end
        chk("lcd_on_delay", n, 32'd100);
        wait_rdy();
        chk("init_done", {31'd0, o_init_done}, 32'd1);
        chk("init_pulses", pulses - base, 32'd4);
    endtask
`endif

    initial begin
        int acc;
        int gap;
        int base;
        logic [7:0] d;
        bit a;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_rdy",  {31'd0, o_req_rdy},   32'd0);
        chk("rst_on",   {31'd0, o_lcd_on},    32'd0);
        chk("rst_en",   {31'd0, o_lcd_en},    32'd0);
        chk("rst_rs",   {31'd0, o_lcd_rs},    32'd0);
        chk("rst_data", {24'd0, o_lcd_data},  32'd0);
        chk("rst_done", {31'd0, o_init_done}, 32'd0);

`ifdef LCD_CTRL_INIT_SEQ_EN
        run_init();
`else
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        chk("norm_rdy",  {31'd0, o_req_rdy},   32'd1);
        chk("norm_on",   {31'd0, o_lcd_on},    32'd1);
        chk("norm_done", {31'd0, o_init_done}, 32'd1);
`endif

        send(1'b1, 8'h41, 19);
        send(1'b0, 8'h01, 59);
        send(1'b1, 8'h01, 19);
        send(1'b0, 8'h02, 59);
        send(1'b0, 8'h38, 19);

        // Held valid across two requests.
        wait_rdy();
        base = pulses; acc = 0; gap = 0; d = 8'h42;
        i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = d;
        for (int c = 0; c < 200 && acc < 2; c++) begin
            a = i_req_vld && o_req_rdy;
            @(posedge i_clk);
            gap++;
            if (a) begin
                exp_q.push_back({1'b1, d});
                acc++;
                if (acc == 2) chk("b2b_gap", gap, 32'd20);
                gap = 0;
                #1;
                d = d + 8'd1;
                i_req_data = d;
                if (acc == 2) i_req_vld = 1'b0;
            end
            @(negedge i_clk);
        end
        i_req_vld = 1'b0;
        chk("b2b_accepts", acc, 32'd2);
        wait_rdy();
        chk("b2b_pulses", pulses - base, 32'd2);
        chk("b2b_queue", exp_q.size(), 32'd0);

        // Reset in the second cycle of PULSE.
        wait_rdy();
        abort = 1'b1;
        i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h55;
        @(posedge i_clk);
        exp_q.push_back({1'b1, 8'h55});
        #1 i_req_vld = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("pulse_before_rst", {31'd0, o_lcd_en}, 32'd1);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_pulse_en",   {31'd0, o_lcd_en},    32'd0);
        chk("rst_pulse_rdy",  {31'd0, o_req_rdy},   32'd0);
        chk("rst_pulse_on",   {31'd0, o_lcd_on},    32'd0);
        chk("rst_pulse_done", {31'd0, o_init_done}, 32'd0);
        repeat (2) @(posedge i_clk);
        abort = 1'b0;
`ifdef LCD_CTRL_INIT_SEQ_EN
        run_init();
        send(1'b1, 8'h41, 19);
`else
        @(negedge i_clk);
        i_reset = 1'b0;
        base = pulses;
        @(posedge i_clk); #1;
        chk("rst2_rdy", {31'd0, o_req_rdy}, 32'd1);
        repeat (40) @(posedge i_clk);
        #1;
        chk("rst2_no_pulses", pulses - base, 32'd0);
        send(1'b1, 8'h41, 19);
`endif

        wait_rdy();
        chk("final_queue", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation timeout");
    end

endmodule

`default_nettype wire
